// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin burst scheduler feeding eight 64-bit sources into one registered output.
module mux8_to_1_x64 (
  input  logic [63:0] X0,
  input  logic [63:0] X1,
  input  logic [63:0] X2,
  input  logic [63:0] X3,
  input  logic [63:0] X4,
  input  logic [63:0] X5,
  input  logic [63:0] X6,
  input  logic [63:0] X7,
  input  logic [2:0]  S,
  input  logic        EN,
  output logic [63:0] Y
);
  logic [63:0] x [8];
  assign x = '{X0, X1, X2, X3, X4, X5, X6, X7};
  assign Y = EN ? x[S] : '0;
endmodule

module mux8_rr_scheduler #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [7:0]  last,
  input  logic [63:0] in_data0,
  input  logic [63:0] in_data1,
  input  logic [63:0] in_data2,
  input  logic [63:0] in_data3,
  input  logic [63:0] in_data4,
  input  logic [63:0] in_data5,
  input  logic [63:0] in_data6,
  input  logic [63:0] in_data7,
  output logic [7:0]  ack,
  input  logic        out_rdy,
  output logic [63:0] out_data,
  output logic        out_wr,
  output logic [2:0]  sel,
  output logic        busy
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [2:0] last_grant, pick;
  logic [7:0] count;
  logic [63:0] mux_y;
  logic transfer, done;
  mux8_to_1_x64 u_mux (
    .X0(in_data0), .X1(in_data1), .X2(in_data2), .X3(in_data3),
    .X4(in_data4), .X5(in_data5), .X6(in_data6), .X7(in_data7),
    .S(sel), .EN(busy), .Y(mux_y)
  );
  // Descending scan so the nearest requester after last_grant wins; last_grant itself is lowest priority.
  always_comb begin
    pick = last_grant;
    for (int k = 8; k >= 1; k--)
      if (req[3'(last_grant + 3'(k))]) pick = 3'(last_grant + 3'(k));
  end
  always_comb begin
    busy = state == BURST;
    transfer = busy & req[sel] & out_rdy;
    done = (transfer & (last[sel] | ({1'b0, count} + 9'd1 == 9'(MAX_BURST)))) | (busy & ~req[sel]);
    ack = transfer ? 8'b1 << sel : '0;
    state_nx = busy ? (done ? IDLE : BURST) : (|req ? BURST : IDLE);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      sel <= '0;
      last_grant <= 3'd7;
      count <= '0;
      out_wr <= 1'b0;
      out_data <= '0;
    end else begin
      out_wr <= transfer;
      if (transfer) begin
        out_data <= mux_y;
        count <= count + 8'(count != 8'hFF);
      end
      if (!busy && |req) begin
        sel <= pick;
        count <= '0;
      end
      if (done) last_grant <= sel;
    end
  end
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// tb_mux8_rr_scheduler: directed scenarios with a data scoreboard for the round-robin burst scheduler.
module tb_mux8_rr_scheduler;
  logic clk = 0, reset = 1, out_rdy = 1;
  logic [7:0] req = 0, last = 0, ack;
  logic [63:0] din [8];
  logic [63:0] out_data;
  logic out_wr, busy;
  logic [2:0] sel;
  logic [7:0] prev_ea = 0;
  logic [63:0] q [$];
  int total = 0, bad = 0;
  mux8_rr_scheduler #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last),
    .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
    .in_data4(din[4]), .in_data5(din[5]), .in_data6(din[6]), .in_data7(din[7]),
    .ack(ack), .out_rdy(out_rdy), .out_data(out_data), .out_wr(out_wr), .sel(sel), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic eb, input logic [2:0] es, input logic [7:0] ea);
    @(negedge clk);
    chk("busy", 64'(busy), 64'(eb));
    chk("sel", 64'(sel), 64'(es));
    chk("ack", 64'(ack), 64'(ea));
    chk("out_wr", 64'(out_wr), 64'(prev_ea != 0));
    if (prev_ea != 0) begin
      if (q.size() == 0) chk("sb_empty", 64'(1), 64'(0));
      else chk("out_data", out_data, q.pop_front());
    end
    if (ea != 0) q.push_back(din[es]);
    prev_ea = ea;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) din[i] = {$urandom, $urandom};
  endtask
  task automatic do_reset();
    reset = 1; req = 0; last = 0; out_rdy = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sel", 64'(sel), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_out_wr", 64'(out_wr), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    reset = 0; prev_ea = 0; q.delete();
  endtask
  initial begin
    for (int i = 0; i < 8; i++) din[i] = {$urandom, $urandom};
    // single-word burst from source 0
    do_reset();
    req = 8'h01; last = 8'h01;
    cyc(0, 0, 0);
    din[0] = 64'hA5A5;
    cyc(1, 0, 8'h01);
    req = 0;
    cyc(0, 0, 0);
    // all requesting, single-word bursts: fair rotation with wrap
    do_reset();
    req = 8'hFF; last = 8'hFF;
    for (int n = 0; n <= 8; n++) begin
      cyc(0, n == 0 ? 3'd0 : 3'(n - 1), 0);
      cyc(1, 3'(n), 8'b1 << 3'(n));
    end
    req = 0;
    cyc(0, 0, 0);
    // burst length cap of 4, then regrant of the only requester
    do_reset();
    req = 8'h08; last = 0;
    cyc(0, 0, 0);
    for (int n = 0; n < 4; n++) cyc(1, 3, 8'h08);
    cyc(0, 3, 0);
    cyc(1, 3, 8'h08);
    req = 0;
    cyc(1, 3, 0);
    cyc(0, 3, 0);
    // stall mid-burst keeps count
    do_reset();
    req = 8'h04;
    cyc(0, 0, 0);
    cyc(1, 2, 8'h04);
    cyc(1, 2, 8'h04);
    out_rdy = 0;
    for (int n = 0; n < 5; n++) cyc(1, 2, 0);
    out_rdy = 1;
    cyc(1, 2, 8'h04);
    cyc(1, 2, 8'h04);
    req = 0;
    cyc(0, 2, 0);
    cyc(0, 2, 0);
    // source 5 drops request, source 6 takes over
    do_reset();
    req = 8'h60;
    cyc(0, 0, 0);
    cyc(1, 5, 8'h20);
    cyc(1, 5, 8'h20);
    req = 8'h40;
    cyc(1, 5, 0);
    cyc(0, 5, 0);
    cyc(1, 6, 8'h40);
    req = 0;
    cyc(1, 6, 0);
    cyc(0, 6, 0);
    // reset mid-burst on source 4 restarts priority at 0
    do_reset();
    req = 8'h10;
    cyc(0, 0, 0);
    cyc(1, 4, 8'h10);
    reset = 1; req = 8'h11;
    cyc(1, 4, 8'h10);
    reset = 0; prev_ea = 0; q.delete();
    cyc(0, 0, 0);
    cyc(1, 0, 8'h01);
    req = 0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux8_rr_scheduler.md
MUX8_RR_SCHEDULER -- requirements
Module: mux8_rr_scheduler

Interface
REQ-001 Parameter MAX_BURST, default 16, is the maximum number of words granted per burst before forced release (range 1..255).
REQ-002 clk  input  1  the single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  8  request from source i; held high while source i has a word presented.
REQ-005 last  input  8  last[i] marks the word currently presented by source i as end-of-burst.
REQ-006 in_data0..in_data7  input  64 each  word presented by source i.
REQ-007 ack  output  8  one-hot; ack[i]=1 means source i's word was consumed this cycle.
REQ-008 out_rdy  input  1  downstream can accept a word this cycle.
REQ-009 out_data  output  64  registered output word.
REQ-010 out_wr  output  1  registered; out_data is valid for exactly this cycle.
REQ-011 sel  output  3  currently granted source index; drives the mux S input.
REQ-012 busy  output  1  high in BURST state.

Function
REQ-013 The datapath shall be one instance of mux8_to_1_x64 with X0..X7=in_data0..7, S=sel, EN=busy.
REQ-014 The FSM shall have two states: IDLE and BURST.
REQ-015 IDLE: if req!=0, the block shall pick the first i with req[i]=1, searching from (last_grant+1) mod 8 upward with wrap to 0; it loads sel=i, clears burst count, and enters BURST next cycle. No ack is issued in IDLE.
REQ-016 IDLE with req=0: the block shall remain in IDLE, sel unchanged.
REQ-017 BURST: transfer = req[sel] & out_rdy; ack[sel]=transfer (combinational); all other ack bits 0.
REQ-018 On transfer, next cycle out_data = in_data[sel] (mux output) and out_wr=1; otherwise out_wr=0 and out_data holds its value.
REQ-019 On transfer, burst count shall increment (8-bit, saturating at 255).
REQ-020 BURST exits to IDLE, with last_grant<=sel, when any of: transfer with last[sel]=1; transfer with count+1==MAX_BURST; req[sel]=0 (no transfer).
REQ-021 out_rdy=0 with req[sel]=1 shall hold BURST, sel and count unchanged (stall, no timeout).
REQ-022 Requests from non-granted sources shall never preempt a burst.
REQ-023 Each grant costs one IDLE bubble cycle; back-to-back bursts shall sustain at most MAX_BURST words per MAX_BURST+1 cycles.
REQ-024 Arbitration shall be fair: with all 8 requesting continuously, grants rotate 0,1,...,7,0 after reset.

Reset
REQ-025 While reset=1 at a clock edge: state=IDLE, sel=0, last_grant=7, count=0, out_wr=0, out_data=0; busy=0 and ack=0 in the following cycle.
REQ-026 Reset asserted mid-burst shall abandon the burst with no ack or out_wr in the reset cycle's aftermath; priority restarts at source 0.

Verification
REQ-027 Reset, then req=8'h01, last=8'h01, in_data0=64'hA5A5, out_rdy=1 -> busy cycle 2, ack[0]=1 cycle 2, out_wr=1 with out_data=64'hA5A5 cycle 3, IDLE cycle 3.
REQ-028 req=8'hFF continuously, last=8'hFF, out_rdy=1 -> sel sequence 0,1,2,...,7,0; one out_wr every 2 cycles.
REQ-029 MAX_BURST=4, req=8'h08, last=0, out_rdy=1 -> 4 consecutive acks to source 3, one idle cycle, then source 3 regranted (only requester).
REQ-030 Burst on source 2, out_rdy=0 for 5 cycles mid-burst -> ack=0, out_wr=0, sel=2, busy=1 throughout; resumes with count preserved.
REQ-031 Source 5 drops req mid-burst with req[6]=1 -> IDLE next cycle, then sel=6, no ack to 5 after drop.
REQ-032 reset=1 during burst on source 4 with out_rdy=1 -> out_wr=0, busy=0 after edge; with req=8'h11 next grant is source 0.
